if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the dynamic pipeline CPU.
- Owns the PC and drives the 11-bit word address into the instruction memory, which returns a 32-bit instruction combinationally in the same cycle.
- Registers the instruction, PC and PC+4 into the IF/ID pipeline register.
- Handles stall, flush and redirect (branch/jump/exception) requests from later stages, and flags bad fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC at reset.
- IMEM_AW, 11, instruction memory word-address width; fetchable range is RESET_PC .. RESET_PC + 4*(2^IMEM_AW) - 1.
- NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on a bubble.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  IMEM_AW  word address to instruction memory.
- imem_instr  in  32  instruction at imem_addr, valid combinationally in the same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  squash the IF/ID contents next edge.
- redir_valid  in  1  load a new PC (branch/jump/exception vector).
- redir_target  in  32  byte address for the redirect.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC.
- id_pc4  out  32  IF/ID PC+4.
- id_valid  out  1  IF/ID holds a real instruction, not a bubble.
- id_fetch_err  out  1  IF/ID instruction came from a misaligned or out-of-range PC.
- fetch_count  out  32  count of instructions committed into IF/ID with id_valid=1.

Behaviour:
- Reset is asynchronous and active-low:
  - pc=RESET_PC.
  - id_instr=NOP_INSTR, id_pc=0, id_pc4=0.
  - id_valid=0, id_fetch_err=0, fetch_count=0.
- First fetch: the first real instruction (from RESET_PC) is in IF/ID one edge after rst_n deasserts, with id_valid=1.
- Address generation: imem_addr = (pc - RESET_PC)[IMEM_AW+1:2]. Purely combinational from the pc register.
- Bad-PC detection, combinational: bad = (pc[1:0]!=0) or (pc-RESET_PC >= 4*2^IMEM_AW).
- When bad, the instruction latched into IF/ID is forced to NOP_INSTR with id_fetch_err=1 and id_valid=1, so a later stage can raise an exception.
- Next-state priority, evaluated each rising edge:
  - 1) redir_valid:
    - pc <= redir_target.
    - IF/ID <= bubble (id_valid=0, id_instr=NOP_INSTR, id_fetch_err=0).
    - Applies regardless of stall or flush.
  - 2) flush, without redir_valid:
    - pc <= pc+4.
    - IF/ID <= bubble.
  - 3) stall:
    - pc and IF/ID hold all values; fetch_count holds.
  - 4) otherwise (normal):
    - pc <= pc+4.
    - IF/ID <= {imem_instr or NOP if bad, pc, pc+4, valid=1, err=bad}.
    - fetch_count += 1.
- Arithmetic: pc+4 wraps modulo 2^32. fetch_count wraps modulo 2^32.
- Redirect to a misaligned target: accepted as-is. The error surfaces on the following fetch via id_fetch_err.
- Stall and flush together, without redirect: flush wins (bubble, pc+4).
- Reset mid-stall or mid-redirect: asynchronous reset overrides everything immediately. Pending requests are dropped.
- Sequential state: pc, IF/ID fields, fetch_count.
- Control is an implicit 2-state FSM:
  - RESET_HOLD: during rst_n=0; outputs at reset values.
  - RUN.
  - The first edge after rst_n rises moves to RUN and performs a normal fetch unless stall, flush or redirect is asserted.

Decomposition:
- Shared cpu package holds:
  - RESET_PC and NOP_INSTR constants.
  - IMEM_AW.
  - A packed if_id_t struct {instr, pc, pc4, valid, fetch_err} reused by the decode stage.
- One natural sub-module: if_id_reg. It is the IF/ID pipeline register with hold/bubble controls, also reusable for the other inter-stage registers.
- The PC logic stays inline in if_fetch_unit.

Test Plan:
- Reset release, no stall; memory word k = 32'h1000_0000+k:
  - -> edge1: id_pc=0, id_instr=32'h1000_0000, id_valid=1.
  - -> edge3: id_pc=8, id_instr=32'h1000_0002.
  - -> fetch_count=3.
- Stall held for 3 cycles starting with id_pc=4:
  - -> imem_addr stays 2.
  - -> id_pc=4 and fetch_count unchanged for 3 cycles.
  - -> resumes with id_pc=8.
- redir_valid with target 32'h0000_0040 while stall=1:
  - -> next edge: id_valid=0, id_instr=0, imem_addr=16.
  - -> following edge (stall=0): id_pc=32'h40.
- flush alone at id_pc=8:
  - -> next edge: id_valid=0.
  - -> the following edge shows id_pc=32'h10; the instruction at 32'h0C is skipped.
- Redirect to 32'h0000_0042:
  - -> next fetch: id_fetch_err=1, id_instr=NOP_INSTR, id_valid=1.
- Redirect to 32'h0000_2000 (word 2048, out of range):
  - -> id_fetch_err=1.
- Reset asserted mid-stall:
  - -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared cpu constants and the IF/ID pipeline record
package if_fetch_unit_pkg;

  localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
  localparam int          CPU_IMEM_AW   = 11;
  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        fetch_err;
  } if_id_t;

  function automatic if_id_t if_id_bubble(input logic [31:0] nop);
    if_id_t b;
    b.instr     = nop;
    b.pc        = '0;
    b.pc4       = '0;
    b.valid     = 1'b0;
    b.fetch_err = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// rtl/if_fetch_unit_if_id_reg.sv - inter-stage pipeline register with hold and bubble controls
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t reg_q;
  if_id_t reg_d;

  // bubble outranks hold so a squash still lands while the stage is stalled
  always_comb begin
    reg_d = reg_q;
    if (bubble)     reg_d = if_id_bubble(NOP_INSTR);
    else if (!hold) reg_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= if_id_bubble(NOP_INSTR);
    else        reg_q <= reg_d;
  end

  assign q = reg_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC owner and instruction fetch into the IF/ID register
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
  parameter int          IMEM_AW   = CPU_IMEM_AW,
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_instr,
  input  logic               stall,
  input  logic               flush,
  input  logic               redir_valid,
  input  logic [31:0]        redir_target,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               id_valid,
  output logic               id_fetch_err,
  output logic [31:0]        fetch_count
);

  localparam logic [32:0] FETCH_SPAN = 33'(4) << IMEM_AW;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_off;
  logic [31:0] pc_plus4;
  logic        bad_pc;
  logic        do_fetch;
  logic        bubble;
  if_id_t      if_id_d, if_id_q;

  assign pc_off    = pc_q - RESET_PC;
  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_off[IMEM_AW+1:2];
  assign bad_pc    = (pc_q[1:0] != 2'b00) || ({1'b0, pc_off} >= FETCH_SPAN);

  assign bubble   = redir_valid || flush;
  assign do_fetch = !bubble && !stall;

  always_comb begin
    pc_d = pc_q;
    if (redir_valid)  pc_d = redir_target;
    else if (flush)   pc_d = pc_plus4;
    else if (!stall)  pc_d = pc_plus4;
  end

  assign fetch_count_d = do_fetch ? fetch_count_q + 32'd1 : fetch_count_q;

  // a bad PC still produces a valid slot so decode can raise the fault in order
  always_comb begin
    if_id_d.instr     = bad_pc ? NOP_INSTR : imem_instr;
    if_id_d.pc        = pc_q;
    if_id_d.pc4       = pc_plus4;
    if_id_d.valid     = 1'b1;
    if_id_d.fetch_err = bad_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (stall),
    .bubble (bubble),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign id_instr     = if_id_q.instr;
  assign id_pc        = if_id_q.pc;
  assign id_pc4       = if_id_q.pc4;
  assign id_valid     = if_id_q.valid;
  assign id_fetch_err = if_id_q.fetch_err;
  assign fetch_count  = fetch_count_q;

endmodule
